// File: rtl/fisr_pkg.sv
// Shared types and constants for the fast inverse square root iterator.
// Also holds the 1.5 - t step used between the second and third multiply.
package fisr_pkg;

    localparam logic [31:0] MAGIC_DEFAULT = 32'h5f3759df;

    localparam logic [31:0] PINF       = 32'h7F800000;
    localparam logic [31:0] QNAN       = 32'h7FC00000;
    localparam logic [31:0] ONE_HALF_Q = 32'h6000_0000;

    localparam logic [1:0] ST_NORMAL = 2'b00;
    localparam logic [1:0] ST_ZERO   = 2'b01;
    localparam logic [1:0] ST_NEG    = 2'b10;
    localparam logic [1:0] ST_INF    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        SQ,
        MX,
        SUB,
        MY,
        DONE
    } state_t;

    // s = 1.5 - t in unsigned Q2.30, truncating; t >= 1.5 gives +0.
    function automatic logic [31:0] one_half_minus(input logic [31:0] t);
        logic [31:0] tq;
        logic [31:0] d;
        logic [31:0] norm;
        logic [7:0]  e;
        int          lz;
        tq = '0;
        e  = t[30:23];
        if (e >= 8'd128) begin
            return '0;
        end
        if (e >= 8'd96) begin
            tq = (32'({1'b1, t[22:0]}) << 7) >> (8'd127 - e);
        end
        if (tq >= ONE_HALF_Q) begin
            return '0;
        end
        d  = ONE_HALF_Q - tq;
        lz = 32;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) begin
                lz = 31 - i;
            end
        end
        norm = d << lz;
        return {1'b0, 8'(128 - lz), norm[30:8]};
    endfunction

endpackage

// File: rtl/fp32_mul.sv
// Combinational fp32 multiply: truncating, denormal operands read as zero,
// underflow flushes to +0, overflow saturates to infinity.
module fp32_mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] prod_c
);

    localparam int unsigned EW = 10;

    logic [23:0]   ma;
    logic [23:0]   mb;
    logic [47:0]   m;
    logic [EW-1:0] e_sum;
    logic [22:0]   frac;
    logic          sign;
    logic          unused_c;

    assign ma       = {1'b1, a[22:0]};
    assign mb       = {1'b1, b[22:0]};
    assign m        = 48'(ma) * 48'(mb);
    assign unused_c = &{1'b0, m[22:0]};

    always_comb begin
        sign   = a[31] ^ b[31];
        e_sum  = EW'(a[30:23]) + EW'(b[30:23]) + EW'(m[47]);
        frac   = m[47] ? m[46:24] : m[45:23];
        prod_c = '0;
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00 || e_sum <= EW'(127)) begin
            prod_c = '0;
        end else if (e_sum >= EW'(382)) begin
            prod_c = {sign, 8'hFF, 23'h0};
        end else begin
            prod_c = {sign, 8'(e_sum - EW'(127)), frac};
        end
    end

endmodule

// File: rtl/fisr_iter.sv
// Sequential fast inverse square root: magic-constant seed followed by ITERS
// Newton-Raphson steps sharing one fp32 multiplier, with a valid/ready result.
module fisr_iter
    import fisr_pkg::*;
#(
    parameter int unsigned ITERS = 1,
    parameter logic [31:0] MAGIC = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_status,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int unsigned IW = 2;

    state_t        state;
    logic [31:0]   x;
    logic [31:0]   y;
    logic [31:0]   xh;
    logic [31:0]   p;
    logic [31:0]   t;
    logic [31:0]   s;
    logic [IW-1:0] iter_left;
    logic [1:0]    cls_c;
    logic [31:0]   mul_a_c;
    logic [31:0]   mul_b_c;
    logic [31:0]   mul_c;

    // Operand class; zero and denormal take precedence over sign.
    always_comb begin
        cls_c = ST_NORMAL;
        if (x[30:23] == 8'h00) begin
            cls_c = ST_ZERO;
        end else if (x[31] || (x[30:23] == 8'hFF && x[22:0] != 23'h0)) begin
            cls_c = ST_NEG;
        end else if (x[30:23] == 8'hFF) begin
            cls_c = ST_INF;
        end
    end

    always_comb begin
        mul_a_c = y;
        mul_b_c = y;
        case (state)
            MX: begin
                mul_a_c = xh;
                mul_b_c = p;
            end
            MY:      mul_b_c = s;
            default: ;
        endcase
    end

    fp32_mul u_mul (
        .a      (mul_a_c),
        .b      (mul_b_c),
        .prod_c (mul_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            xh         <= '0;
            p          <= '0;
            t          <= '0;
            s          <= '0;
            iter_left  <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_data   <= '0;
            out_status <= ST_NORMAL;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x        <= in_data;
                        state    <= SEED;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SEED: begin
                    y         <= MAGIC - (x >> 1);
                    xh        <= {1'b0, x[30:23] - 8'd1, x[22:0]};
                    iter_left <= IW'(ITERS - 1);
                    state     <= (ITERS == 0 || cls_c != ST_NORMAL) ? DONE : SQ;
                end
                SQ: begin
                    p     <= mul_c;
                    state <= MX;
                end
                MX: begin
                    t     <= mul_c;
                    state <= SUB;
                end
                SUB: begin
                    s     <= one_half_minus(t);
                    state <= MY;
                end
                MY: begin
                    y <= mul_c;
                    if (iter_left != '0) begin
                        iter_left <= iter_left - IW'(1);
                        state     <= SQ;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle loads the result; afterwards hold until taken.
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        out_status <= cls_c;
                        case (cls_c)
                            ST_ZERO: out_data <= PINF;
                            ST_NEG:  out_data <= QNAN;
                            ST_INF:  out_data <= '0;
                            default: out_data <= y;
                        endcase
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
